rib_xbar: RTL
=============

// Module: rib_xbar
// PURPOSE
//  Parametrised RIB bus interconnect: NUM_M masters to NUM_S slaves with registered, locking grant.
//  Fixed-priority or round-robin arbitration; slave select by address top bits.
//  Sits between the tinyriscv core, jtag/uart_debug masters and the rom/ram/timer/uart/gpio/spi slaves.
//  hold_flag_o stalls the core pipeline while a non-fetch master owns the bus.
// PARAMETERS
//  NUM_M        4    number of masters (2..8)
//  NUM_S        6    number of slaves (1..16)
//  AW           32   address width
//  DW           32   data width
//  SEL_BITS     4    addr[AW-1 -: SEL_BITS] = slave index
//  FETCH_M      1    index of the core instruction-fetch master (park master, never locks)
//  ARB_RR       0    0: fixed priority, highest index wins; 1: round-robin
// PORTS
//  clk          in   1         system clock
//  rst          in   1         synchronous reset, active-high
//  m_addr_i     in   NUM_M*AW  master addresses, master k at [k*AW +: AW]
//  m_data_i     in   NUM_M*DW  master write data
//  m_data_o     out  NUM_M*DW  read data returned to masters
//  m_req_i      in   NUM_M     master request
//  m_we_i       in   NUM_M     master write enable
//  m_gnt_o      out  NUM_M     one-hot current owner
//  s_addr_o     out  NUM_S*AW  slave addresses
//  s_data_o     out  NUM_S*DW  slave write data
//  s_data_i     in   NUM_S*DW  slave read data
//  s_we_o       out  NUM_S     slave write enable
//  hold_flag_o  out  1         pipeline hold to core
// BEHAVIOUR
//  - Reset: owner_q=FETCH_M, rr_ptr_q=0; m_gnt_o=onehot(FETCH_M); all s_we_o=0; hold_flag_o=0 once rst samples low.
//  - Next owner each edge: if owner_q!=FETCH_M and m_req_i[owner_q] -> keep (lock);
//    else if any req from masters != FETCH_M -> arbiter winner; else FETCH_M (park).
//  - Fixed: highest index among eligible wins. RR: first eligible after rr_ptr_q (mod NUM_M); rr_ptr_q<=winner on grant.
//  - Latency: req at cycle N -> m_gnt_o/data path for that master from N+1. Release: req low at M -> re-arbitrate, new owner at M+1.
//  - hold_flag_o = (owner_q!=FETCH_M) | (|(m_req_i & ~onehot(FETCH_M))): combinational, asserts in cycle N.
//  - Data path combinational from owner: sel=owner addr top bits; s_addr/s_data of sel = owner's; s_we_o[sel]=m_we_i[owner]&m_req_i[owner] (FETCH_M: req treated as 1).
//  - Non-selected slaves: addr/data 0, we 0. m_data_o of owner = s_data_i[sel]; all other masters get 0.
//  - sel>=NUM_S (unmapped): write dropped, read returns 0.
//  - Simultaneous release by owner and new reqs: arbitration excludes nothing; releasing master may win again if still requesting (it is not).
//  - rst asserted mid-transfer: owner forced to FETCH_M next edge, lock lost, no slave write after that edge.
// CONFIGURATION
//  RIB_DECERR_EN defined: adds ports dec_err_o (out 1: one-cycle pulse, registered, cycle after owner accesses unmapped sel)
//   and err_addr_o (out AW: address of last unmapped access, reset 0, held until next error).
//  RIB_DECERR_EN undefined: ports absent; unmapped accesses silently ignored as above.
// STRUCTURE
//  rib_pkg.vh (shared include): RIB_SEL_BITS default, RIB_FETCH_M, onehot/index helper functions, ZeroWord.
//  Sub-module rib_arb: NUM_M request vector + rr pointer + mode -> winner index/valid; pure combinational.
//  Top holds owner_q, rr_ptr_q, decode, muxes and optional error regs.
// TESTING
//  1 Reset, no reqs -> m_gnt_o=4'b0010, hold_flag_o=0, fetch reads rom at 0x0000_0000.
//  2 m0 req write 0x1000_0004=0xDEADBEEF at N -> hold_flag_o=1 at N, m_gnt_o=0001 and s_we_o[1]=1 at N+1.
//  3 Fixed: m0,m2,m3 req same cycle -> m3 owns; after m3 drops, m2 next, then m0; fetch parked at end.
//  4 ARB_RR=1: m0,m2,m3 req continuously toggling each access -> grants rotate 0,2,3,0; no starvation in 12 cycles.
//  5 Unmapped addr 0xF000_0000 read by m2 -> m_data_o=0, no s_we_o; with RIB_DECERR_EN dec_err_o pulse, err_addr_o=0xF000_0000.
//  6 rst high while m3 owns with we=1 -> next edge m_gnt_o=0010, s_we_o all 0.

Source files
------------

// File: rtl/rib_xbar_pkg.sv
// rib_xbar_pkg
// Shared definitions for the RIB interconnect: default slave-select width,
// default fetch (park) master index, a zero bus word and small helpers for
// one-hot vectors and index widths.
// No ports; imported by rib_xbar and rib_xbar_arb.
package rib_xbar_pkg;

    localparam int RIB_SEL_BITS = 4;
    localparam int RIB_FETCH_M  = 1;
    localparam int MAX_M        = 8;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // One-hot vector with bit idx set, sized for the largest master count.
    function automatic logic [MAX_M-1:0] onehotIdx(input int unsigned idx);
        logic [MAX_M-1:0] v;
        v = '0;
        v[idx[2:0]] = 1'b1;
        return v;
    endfunction

    // Width of an index able to address n items (at least one bit).
    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rib_xbar_arb.sv
// rib_xbar_arb
// Purely combinational arbiter for the RIB interconnect. The fetch master is
// never eligible here: it only ever gets the bus by parking.
// Ports:
//   req_i     in   NUM_M  master request vector
//   ptr_i     in   IW     round-robin pointer (index of the last winner)
//   rr_i      in   1      0: fixed priority, highest index wins; 1: round-robin
//   winner_o  out  IW     index of the winning master
//   valid_o   out  1      at least one eligible (non-fetch) request
module rib_xbar_arb #(
    parameter int NUM_M   = 4,
    parameter int IW      = 2,
    parameter int FETCH_M = 1
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    input  logic             rr_i,
    output logic [IW-1:0]    winner_o,
    output logic             valid_o
);

    logic [NUM_M-1:0] eligible;

    // Both loops rely on "last assignment wins". The fixed-priority loop walks
    // upward so the highest index survives. The round-robin loop walks from the
    // farthest offset back toward ptr+1, so the first eligible master after the
    // pointer survives.
    always_comb begin
        eligible          = req_i;
        eligible[FETCH_M] = 1'b0;
        valid_o           = |eligible;
        winner_o          = '0;
        if (rr_i) begin
            for (int k = NUM_M; k >= 1; k--) begin
                if (eligible[(int'(ptr_i) + k) % NUM_M]) begin
                    winner_o = IW'((int'(ptr_i) + k) % NUM_M);
                end
            end
        end else begin
            for (int i = 0; i < NUM_M; i++) begin
                if (eligible[i]) begin
                    winner_o = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rib_xbar.sv
// rib_xbar
// RIB bus interconnect: NUM_M masters to NUM_S slaves with a registered,
// locking grant. The fetch master parks on the bus when nobody else wants it.
// hold_flag_o stalls the core while a non-fetch master owns or requests the bus.
// Optional feature macro: RIB_DECERR_EN (adds dec_err_o / err_addr_o).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   m_addr_i      NUM_M*AW  master addresses (master k at [k*AW +: AW])
//   m_data_i      NUM_M*DW  master write data
//   m_data_o      NUM_M*DW  read data; only the owner gets non-zero data
//   m_req_i       NUM_M     master requests
//   m_we_i        NUM_M     master write enables
//   m_gnt_o       NUM_M     one-hot current owner
//   s_addr_o      NUM_S*AW  slave addresses (only the selected slave is non-zero)
//   s_data_o      NUM_S*DW  slave write data
//   s_data_i      NUM_S*DW  slave read data
//   s_we_o        NUM_S     slave write enables
//   hold_flag_o   1         pipeline hold to the core
//   dec_err_o     1         (RIB_DECERR_EN) registered pulse after an unmapped access
//   err_addr_o    AW        (RIB_DECERR_EN) address of the last unmapped access
module rib_xbar
    import rib_xbar_pkg::*;
#(
    parameter int NUM_M    = 4,
    parameter int NUM_S    = 6,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int SEL_BITS = RIB_SEL_BITS,
    parameter int FETCH_M  = RIB_FETCH_M,
    parameter int ARB_RR   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_data_i,
    output logic [NUM_M*DW-1:0] m_data_o,
    input  logic [NUM_M-1:0]    m_req_i,
    input  logic [NUM_M-1:0]    m_we_i,
    output logic [NUM_M-1:0]    m_gnt_o,
    output logic [NUM_S*AW-1:0] s_addr_o,
    output logic [NUM_S*DW-1:0] s_data_o,
    input  logic [NUM_S*DW-1:0] s_data_i,
    output logic [NUM_S-1:0]    s_we_o,
    output logic                hold_flag_o
`ifdef RIB_DECERR_EN
    ,
    output logic                dec_err_o,
    output logic [AW-1:0]       err_addr_o
`endif
);

    localparam int                IW         = idxWidth(NUM_M);
    localparam logic [IW-1:0]     FetchIdx   = IW'(FETCH_M);
    localparam logic [MAX_M-1:0]  FetchOhAll = onehotIdx(FETCH_M);
    localparam logic [NUM_M-1:0]  FetchOh    = FetchOhAll[NUM_M-1:0];

    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       rrPtr_q, rrPtr_d;
    logic [IW-1:0]       arbWinner;
    logic                arbValid;
    logic                ownerIsFetch;
    logic [AW-1:0]       ownerAddr;
    logic [DW-1:0]       ownerData;
    logic                ownerWe;
    logic                ownerReq;
    logic [SEL_BITS-1:0] sel;
    logic                selMapped;

    rib_xbar_arb #(
        .NUM_M   (NUM_M),
        .IW      (IW),
        .FETCH_M (FETCH_M)
    ) u_arb (
        .req_i    (m_req_i),
        .ptr_i    (rrPtr_q),
        .rr_i     (ARB_RR != 0),
        .winner_o (arbWinner),
        .valid_o  (arbValid)
    );

    // Decode the owner's request and slave select. The parked fetch master is
    // treated as always requesting so the core can fetch without a handshake.
    always_comb begin
        ownerIsFetch = (owner_q == FetchIdx);
        ownerAddr    = m_addr_i[int'(owner_q)*AW +: AW];
        ownerData    = m_data_i[int'(owner_q)*DW +: DW];
        ownerWe      = m_we_i[owner_q];
        ownerReq     = ownerIsFetch ? 1'b1 : m_req_i[owner_q];
        sel          = ownerAddr[AW-1 -: SEL_BITS];
        selMapped    = ({1'b0, sel} < (SEL_BITS+1)'(NUM_S));
    end

    // Next owner: a non-fetch owner keeps the bus while it keeps requesting.
    // Otherwise the arbiter picks among the other requesters, and with none the
    // bus parks on the fetch master. The round-robin pointer only moves on a
    // fresh grant, so a long locked transfer does not disturb rotation.
    always_comb begin
        owner_d = owner_q;
        rrPtr_d = rrPtr_q;
        if (!ownerIsFetch && m_req_i[owner_q]) begin
            owner_d = owner_q;
        end else if (arbValid) begin
            owner_d = arbWinner;
            rrPtr_d = arbWinner;
        end else begin
            owner_d = FetchIdx;
        end
    end

    // Ownership state. Reset drops any lock and parks the bus on fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= FetchIdx;
            rrPtr_q <= '0;
        end else begin
            owner_q <= owner_d;
            rrPtr_q <= rrPtr_d;
        end
    end

    // Route the owner to the selected slave and the read data back to the
    // owner only. Unmapped selects reach no slave and read back zero. Writes
    // are also blocked while reset is high so a reset mid-transfer cannot
    // leave a stray strobe on a slave.
    always_comb begin
        s_addr_o = '0;
        s_data_o = '0;
        s_we_o   = '0;
        m_data_o = '0;
        if (selMapped) begin
            s_addr_o[int'(sel)*AW +: AW]     = ownerAddr;
            s_data_o[int'(sel)*DW +: DW]     = ownerData;
            s_we_o[sel]                      = ownerWe & ownerReq & ~rst;
            m_data_o[int'(owner_q)*DW +: DW] = s_data_i[int'(sel)*DW +: DW];
        end
    end

    // Grant mirrors the registered owner. The hold flag goes up as soon as a
    // non-fetch master asks, a cycle before it actually owns the bus.
    always_comb begin
        m_gnt_o          = '0;
        m_gnt_o[owner_q] = 1'b1;
        hold_flag_o      = !ownerIsFetch || (|(m_req_i & ~FetchOh));
    end

`ifdef RIB_DECERR_EN
    logic          decErr_q;
    logic [AW-1:0] errAddr_q;

    // Unmapped-access capture. The pulse is registered and appears the cycle
    // after the access. The address is held until the next error.
    always_ff @(posedge clk) begin
        if (rst) begin
            decErr_q  <= 1'b0;
            errAddr_q <= '0;
        end else begin
            decErr_q <= ownerReq & ~selMapped;
            if (ownerReq && !selMapped) begin
                errAddr_q <= ownerAddr;
            end
        end
    end

    assign dec_err_o  = decErr_q;
    assign err_addr_o = errAddr_q;
`endif

endmodule
